// File: rtl/pdes_mc_pkg.sv
// Shared memory-controller protocol constants and types.
// Provides the MC command, response and size encodings used on the mc_rq_*/mc_rs_*
// ports. It also provides the struct for the registered request stage and a helper
// that maps a stored op to the response command expected for it.
package pdes_mc_pkg;

  localparam logic [2:0] MC_CMD_RD      = 3'd1;
  localparam logic [2:0] MC_CMD_WR      = 3'd2;
  localparam logic [2:0] MC_RSP_RD_DATA = 3'd2;
  localparam logic [2:0] MC_RSP_WR_CMP  = 3'd3;
  localparam logic [1:0] MC_SIZE_8B     = 2'd3;

  typedef struct packed {
    logic        vld;
    logic [2:0]  cmd;
    logic [47:0] vadr;
    logic [63:0] data;
  } mc_rq_t;

  // Response command that legitimately completes a request of the given op.
  function automatic logic [2:0] rsp_cmd_for(input logic wr);
    return wr ? MC_RSP_WR_CMP : MC_RSP_RD_DATA;
  endfunction

endpackage

// File: rtl/mc_tag_alloc.sv
// Tag allocator for outstanding MC requests.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   alloc              take alloc_tag this cycle; only asserted when avail is high
//   free, free_tag     release free_tag this cycle
//   avail, alloc_tag   a tag is obtainable, and the lowest-index one
//   busy               tag-in-use bitmap
//   count              registered popcount of busy
// A tag that is being freed in this cycle counts as open. It can therefore be
// handed out again in the same cycle. In that case the free and the alloc cancel,
// and the bit stays set.
module mc_tag_alloc #(
  parameter  int NUM_TAGS = 8,
  localparam int TAG_WID  = $clog2(NUM_TAGS),
  localparam int CNT_WID  = TAG_WID + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc,
  input  logic                free,
  input  logic [TAG_WID-1:0]  free_tag,
  output logic                avail,
  output logic [TAG_WID-1:0]  alloc_tag,
  output logic [NUM_TAGS-1:0] busy,
  output logic [CNT_WID-1:0]  count
);

  logic [NUM_TAGS-1:0] free_mask, alloc_mask, open, busy_nxt;
  logic [CNT_WID-1:0]  cnt_nxt;

  always_comb begin
    free_mask = '0;
    if (free) free_mask[free_tag] = 1'b1;
  end

  assign open = ~busy | free_mask;

  // Scan from the top down so that the lowest open index is the last one written.
  always_comb begin
    avail     = 1'b0;
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (open[i]) begin
        avail     = 1'b1;
        alloc_tag = TAG_WID'(i);
      end
    end
  end

  always_comb begin
    alloc_mask = '0;
    if (alloc) alloc_mask[alloc_tag] = 1'b1;
  end

  assign busy_nxt = (busy & ~free_mask) | alloc_mask;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_TAGS; i++) cnt_nxt = cnt_nxt + CNT_WID'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_nxt;
      count <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mc_req_client.sv
// Memory-controller request client for LP-state traffic.
// This module accepts 8 B read and write requests from a core arbiter (req_*). It
// issues each request through a registered MC request stage (mc_rq_*). It tracks
// each request by the tag carried in rtnctl. It routes each MC response (mc_rs_*)
// back to the originating core through a registered response stage (rsp_*).
// Ports:
//   req_vld/req_rdy/req_wr/req_addr/req_data/req_id   core request handshake
//   rsp_vld/rsp_wr/rsp_id/rsp_data, rsp_stall          core response, with back-pressure
//   mc_rq_*  (mc_rq_stall in)                          MC request port
//   mc_rs_*  (mc_rs_stall out)                         MC response port
//   outstanding                                        tags in use
//   err_unexp                                          sticky flag for unexpected responses
module mc_req_client
  import pdes_mc_pkg::*;
#(
  parameter  int MC_RTNCTL_WIDTH = 32,
  parameter  int NUM_TAGS        = 8,
  parameter  int ID_WID          = 4,
  localparam int TAG_WID         = $clog2(NUM_TAGS),
  localparam int CNT_WID         = TAG_WID + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_vld,
  input  logic                       req_wr,
  input  logic [47:0]                req_addr,
  input  logic [63:0]                req_data,
  input  logic [ID_WID-1:0]          req_id,
  output logic                       req_rdy,
  output logic                       rsp_vld,
  output logic                       rsp_wr,
  output logic [ID_WID-1:0]          rsp_id,
  output logic [63:0]                rsp_data,
  input  logic                       rsp_stall,
  output logic                       mc_rq_vld,
  output logic [2:0]                 mc_rq_cmd,
  output logic [3:0]                 mc_rq_scmd,
  output logic [47:0]                mc_rq_vadr,
  output logic [1:0]                 mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [63:0]                mc_rq_data,
  output logic                       mc_rq_flush,
  input  logic                       mc_rq_stall,
  input  logic                       mc_rs_vld,
  input  logic [2:0]                 mc_rs_cmd,
  input  logic [3:0]                 mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic [63:0]                mc_rs_data,
  output logic                       mc_rs_stall,
  output logic [CNT_WID-1:0]         outstanding,
  output logic                       err_unexp
);

  logic                           tag_avail;
  logic [TAG_WID-1:0]             alloc_tag;
  logic [NUM_TAGS-1:0]            busy;
  logic                           req_acc;
  logic                           rs_acc, rs_good, rs_cmd_ok, rs_hi_zero;
  logic [TAG_WID-1:0]             rs_tag;
  logic [NUM_TAGS-1:0]            tbl_wr;
  logic [NUM_TAGS-1:0][ID_WID-1:0] tbl_id;
  mc_rq_t                         rq_q;
  logic [TAG_WID-1:0]             rq_tag_q;
  logic                           rq_sized_q;
  logic                           unused_ok;

  assign unused_ok = ^mc_rs_scmd;

  mc_tag_alloc #(.NUM_TAGS(NUM_TAGS)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .alloc     (req_acc),
    .free      (rs_good),
    .free_tag  (rs_tag),
    .avail     (tag_avail),
    .alloc_tag (alloc_tag),
    .busy      (busy),
    .count     (outstanding)
  );

  // ---------------- issue ----------------
  // The request stage can load whenever it is empty or being drained in this cycle.
  assign req_rdy = tag_avail && (!rq_q.vld || !mc_rq_stall);
  assign req_acc = req_vld && req_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      rq_q       <= '0;
      rq_tag_q   <= '0;
      rq_sized_q <= 1'b0;
    end else if (req_acc) begin
      rq_q       <= '{vld: 1'b1, cmd: (req_wr ? MC_CMD_WR : MC_CMD_RD),
                      vadr: req_addr, data: (req_wr ? req_data : 64'd0)};
      rq_tag_q   <= alloc_tag;
      rq_sized_q <= 1'b1;
    end else if (!mc_rq_stall) begin
      rq_q.vld   <= 1'b0;
    end
  end

  assign mc_rq_vld    = rq_q.vld;
  assign mc_rq_cmd    = rq_q.cmd;
  assign mc_rq_vadr   = rq_q.vadr;
  assign mc_rq_data   = rq_q.data;
  assign mc_rq_rtnctl = MC_RTNCTL_WIDTH'(rq_tag_q);
  assign mc_rq_size   = rq_sized_q ? MC_SIZE_8B : 2'd0;  // all-zero out of reset
  assign mc_rq_scmd   = 4'd0;
  assign mc_rq_flush  = 1'b0;

  // The table is written only at accept. It is read only for tags marked busy, so
  // it needs no reset.
  always_ff @(posedge clk) begin
    if (req_acc) begin
      tbl_wr[alloc_tag] <= req_wr;
      tbl_id[alloc_tag] <= req_id;
    end
  end

  // ---------------- response ----------------
  assign mc_rs_stall = rsp_vld && rsp_stall;
  assign rs_acc      = mc_rs_vld && !mc_rs_stall;
  assign rs_tag      = mc_rs_rtnctl[TAG_WID-1:0];
  assign rs_hi_zero  = (mc_rs_rtnctl[MC_RTNCTL_WIDTH-1:TAG_WID] == '0);
  assign rs_cmd_ok   = (mc_rs_cmd == rsp_cmd_for(tbl_wr[rs_tag]));
  assign rs_good     = rs_acc && busy[rs_tag] && rs_cmd_ok && rs_hi_zero;

  // If rs_acc is high, the rsp stage is either empty or draining, so loading it is safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld  <= 1'b0;
      rsp_wr   <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (rs_good) begin
      rsp_vld  <= 1'b1;
      rsp_wr   <= tbl_wr[rs_tag];
      rsp_id   <= tbl_id[rs_tag];
      rsp_data <= tbl_wr[rs_tag] ? 64'd0 : mc_rs_data;
    end else if (!rsp_stall) begin
      rsp_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   err_unexp <= 1'b0;
    else if (rs_acc && !rs_good) err_unexp <= 1'b1;
  end

endmodule

// File: tb/tb_mc_req_client.sv
// Bench for mc_req_client. The bench plays two roles: the core, which issues
// requests, and a memory controller, which answers them out of an associative
// memory. Requests and responses are tracked at the transaction level by a monitor.
// The monitor checks every MC request against the order in which requests were
// accepted. It checks every core response against a scoreboard queue of
// expected responses.
module tb_mc_req_client;
  import pdes_mc_pkg::*;

  localparam int NT = 8;
  localparam int IW = 4;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_vld = 1'b0, req_wr = 1'b0;
  logic [47:0]   req_addr = '0;
  logic [63:0]   req_data = '0;
  logic [IW-1:0] req_id = '0;
  logic          req_rdy;
  logic          rsp_vld, rsp_wr;
  logic [IW-1:0] rsp_id;
  logic [63:0]   rsp_data;
  logic          rsp_stall = 1'b0;
  logic          mc_rq_vld, mc_rq_flush;
  logic [2:0]    mc_rq_cmd;
  logic [3:0]    mc_rq_scmd;
  logic [47:0]   mc_rq_vadr;
  logic [1:0]    mc_rq_size;
  logic [RW-1:0] mc_rq_rtnctl;
  logic [63:0]   mc_rq_data;
  logic          mc_rq_stall = 1'b0;
  logic          mc_rs_vld = 1'b0;
  logic [2:0]    mc_rs_cmd = '0;
  logic [3:0]    mc_rs_scmd = '0;
  logic [RW-1:0] mc_rs_rtnctl = '0;
  logic [63:0]   mc_rs_data = '0;
  logic          mc_rs_stall;
  logic [3:0]    outstanding;
  logic          err_unexp;

  mc_req_client #(.MC_RTNCTL_WIDTH(RW), .NUM_TAGS(NT), .ID_WID(IW)) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .req_id(req_id), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_wr(rsp_wr), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_stall(rsp_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [47:0] addr; logic [63:0] data; logic [IW-1:0] id; } creq_t;
  typedef struct packed { logic wr; logic [IW-1:0] id; logic [63:0] data; } rsp_t;

  // model state
  creq_t             pend_q[$];     // accepted from the core, not yet issued on the MC
  rsp_t              sb_q[$];       // responses the core is owed, in order
  rsp_t              tag_exp[NT];
  bit                tag_busy[NT];  // issued on the MC and not yet answered
  int                pool[$];       // tags the fake MC may answer
  int                issued_tags[$];
  logic [63:0]       mem [logic [47:0]];
  int                n_out = 0;
  bit                exp_err = 0;
  bit                rs_taken = 0, rs_flush = 0;
  // knobs
  int                rq_stall_pct = 0, rsp_stall_pct = 0;
  bit                rsp_en = 1;
  bit                inject_pend = 0;
  int                inject_tag = 0;
  int                checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fake MC responder and random back-pressure. It drives at the negedge.
  initial begin : responder
    int idx, t;
    forever begin
      @(negedge clk);
      mc_rq_stall = (int'($urandom_range(0, 99)) < rq_stall_pct);
      rsp_stall   = (int'($urandom_range(0, 99)) < rsp_stall_pct);
      if (rs_flush) begin
        rs_flush = 0; rs_taken = 0; mc_rs_vld = 1'b0;
      end else if (rs_taken || !mc_rs_vld) begin
        rs_taken = 0; mc_rs_vld = 1'b0;
        if (inject_pend) begin
          inject_pend  = 0;
          mc_rs_vld    = 1'b1;
          mc_rs_rtnctl = RW'(inject_tag);
          mc_rs_cmd    = MC_RSP_RD_DATA;
          mc_rs_data   = 64'h0BAD_0BAD;
        end else if (rsp_en && pool.size() > 0 && $urandom_range(0, 99) < 70) begin
          idx = int'($urandom_range(0, pool.size() - 1));
          t   = pool[idx];
          pool.delete(idx);
          mc_rs_vld    = 1'b1;
          mc_rs_rtnctl = RW'(t);
          mc_rs_cmd    = tag_exp[t].wr ? MC_RSP_WR_CMP : MC_RSP_RD_DATA;
          mc_rs_data   = tag_exp[t].wr ? {$urandom, $urandom} : tag_exp[t].data;
        end
      end
    end
  end

  // Monitor. It samples 2 ns after the negedge, when every input is settled. It
  // then predicts which handshakes will complete at the next posedge.
  initial begin : monitor
    rsp_t  r;
    creq_t c;
    int    t, t2;
    bit    gd, rs_acc, rq_hold, rsp_hold, was_rst;
    logic [2:0]    p_cmd;
    logic [47:0]   p_vadr;
    logic [63:0]   p_data, p_rdata;
    logic [RW-1:0] p_rtn;
    logic          p_wr;
    logic [IW-1:0] p_id;
    rq_hold = 0; rsp_hold = 0; was_rst = 0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        pend_q.delete(); sb_q.delete(); pool.delete();
        for (int i = 0; i < NT; i++) tag_busy[i] = 0;
        n_out = 0; exp_err = 0; rq_hold = 0; rsp_hold = 0; was_rst = 1;
        rs_flush = 1; rs_taken = 0;
        continue;
      end
      if (was_rst) begin
        was_rst = 0;
        chk("rst_mc_rq_vld", mc_rq_vld, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rtnctl", mc_rq_rtnctl, 0);
      end
      chk("outstanding", outstanding, n_out);
      chk("err_unexp", err_unexp, exp_err);
      chk("mc_rs_stall", mc_rs_stall, rsp_vld & rsp_stall);
      if (rq_hold) begin
        chk("rq_hold_vld", mc_rq_vld, 1);
        chk("rq_hold_cmd", mc_rq_cmd, p_cmd);
        chk("rq_hold_vadr", mc_rq_vadr, p_vadr);
        chk("rq_hold_data", mc_rq_data, p_data);
        chk("rq_hold_rtnctl", mc_rq_rtnctl, p_rtn);
      end
      if (rsp_hold) begin
        chk("rsp_hold_vld", rsp_vld, 1);
        chk("rsp_hold_wr", rsp_wr, p_wr);
        chk("rsp_hold_id", rsp_id, p_id);
        chk("rsp_hold_data", rsp_data, p_rdata);
      end

      rs_acc = mc_rs_vld && !(rsp_vld && rsp_stall);
      gd = 0; t = 0;
      if (rs_acc) begin
        t  = int'(mc_rs_rtnctl[2:0]);
        gd = tag_busy[t] && (mc_rs_rtnctl[RW-1:3] == '0) &&
             (mc_rs_cmd == (tag_exp[t].wr ? MC_RSP_WR_CMP : MC_RSP_RD_DATA));
      end
      chk("req_rdy", req_rdy, 64'((n_out < NT || gd) && (!mc_rq_vld || !mc_rq_stall)));

      if (rsp_vld && !rsp_stall) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_vld=1 id=%0h expected no response", rsp_id);
        end else begin
          r = sb_q.pop_front();
          chk("rsp_wr", rsp_wr, r.wr);
          chk("rsp_id", rsp_id, r.id);
          chk("rsp_data", rsp_data, r.data);
        end
      end
      if (rs_acc) begin
        rs_taken = 1;
        if (gd) begin sb_q.push_back(tag_exp[t]); tag_busy[t] = 0; end
        else exp_err = 1;
      end

      if (mc_rq_vld && !mc_rq_stall) begin
        if (pend_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rq_unexpected: got mc_rq_vld=1 expected no request");
        end else begin
          c  = pend_q.pop_front();
          t2 = int'(mc_rq_rtnctl[2:0]);
          chk("rq_cmd", mc_rq_cmd, c.wr ? MC_CMD_WR : MC_CMD_RD);
          chk("rq_vadr", mc_rq_vadr, c.addr);
          chk("rq_data", mc_rq_data, c.wr ? c.data : 64'd0);
          chk("rq_size", mc_rq_size, MC_SIZE_8B);
          chk("rq_scmd", mc_rq_scmd, 0);
          chk("rq_flush", mc_rq_flush, 0);
          chk("rq_rtnctl_hi", mc_rq_rtnctl >> 3, 0);
          chk("rq_tag_free", tag_busy[t2], 0);
          issued_tags.push_back(t2);
          if (c.wr) begin
            mem[c.addr] = c.data;
            tag_exp[t2] = '{wr: 1'b1, id: c.id, data: 64'd0};
          end else begin
            tag_exp[t2] = '{wr: 1'b0, id: c.id, data: (mem.exists(c.addr) ? mem[c.addr] : 64'd0)};
          end
          tag_busy[t2] = 1;
          pool.push_back(t2);
        end
      end
      if (req_vld && req_rdy) begin
        pend_q.push_back('{wr: req_wr, addr: req_addr, data: req_data, id: req_id});
        n_out++;
      end
      if (gd) n_out--;

      rq_hold = mc_rq_vld && mc_rq_stall;
      p_cmd = mc_rq_cmd; p_vadr = mc_rq_vadr; p_data = mc_rq_data; p_rtn = mc_rq_rtnctl;
      rsp_hold = rsp_vld && rsp_stall;
      p_wr = rsp_wr; p_id = rsp_id; p_rdata = rsp_data;
    end
  end

  task automatic send(input bit wr, input logic [47:0] a, input logic [63:0] d, input logic [IW-1:0] id);
    bit done = 0;
    @(negedge clk);
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_data = d; req_id = id;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (req_rdy) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL send_timeout: got req_rdy=0 expected 1 within 200 cycles"); end
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic rand_cycles(input int n, input int pct);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req_vld  = (int'($urandom_range(0, 99)) < pct);
      req_wr   = $urandom_range(0, 1);
      req_addr = {41'd0, 4'($urandom_range(0, 15)), 3'b000};
      req_data = {$urandom, $urandom};
      req_id   = IW'($urandom_range(0, 15));
    end
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    req_vld = 1'b0; rsp_en = 1; rq_stall_pct = 0; rsp_stall_pct = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (n_out == 0 && sb_q.size() == 0 && pend_q.size() == 0 && !rsp_vld && !mc_rq_vld && !mc_rs_vld)
        ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d outstanding expected 0 within 1000 cycles", name, n_out);
    end
    #3 chk({name, "_outstanding"}, outstanding, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3 chk("reset_req_rdy", req_rdy, 1);
    chk("reset_outstanding", outstanding, 0);

    // Write, then a read of the same address, each returned to its own id.
    send(1, 48'h40, 64'hDEAD_BEEF, 4'd3);
    send(0, 48'h40, 64'h0, 4'd5);
    drain("t1_drain");

    // With no responses, the DUT fills all 8 tags in order and then refuses more.
    rsp_en = 0;
    issued_tags.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 48'(k * 8); req_id = IW'(k);
    end
    @(negedge clk); req_vld = 1'b0;
    #3;
    chk("fill_outstanding", outstanding, NT);
    chk("fill_req_rdy", req_rdy, 0);
    chk("fill_issued", issued_tags.size(), NT);
    for (int i = 0; i < NT && i < issued_tags.size(); i++) chk("fill_tag_order", issued_tags[i], i);
    drain("t2_drain");

    // Request stall held for 5 cycles while traffic is flowing.
    fork
      rand_cycles(12, 100);
      begin
        repeat (3) @(negedge clk);
        rq_stall_pct = 100;
        repeat (5) @(negedge clk);
        rq_stall_pct = 0;
      end
    join
    drain("t3_drain");

    // Core response stall held for 4 cycles while read data returns.
    send(0, 48'h40, 64'h0, 4'd1);
    send(0, 48'h48, 64'h0, 4'd2);
    send(0, 48'h40, 64'h0, 4'd7);
    rsp_stall_pct = 100;
    repeat (4) @(negedge clk);
    rsp_stall_pct = 0;
    drain("t4_drain");

    // Response on an idle tag while two requests are outstanding.
    rsp_en = 0;
    send(0, 48'h10, 64'h0, 4'd4);
    send(1, 48'h18, 64'h1234, 4'd6);
    repeat (3) @(negedge clk);
    inject_tag = 6; inject_pend = 1;
    repeat (4) @(negedge clk);
    #3 chk("idle_tag_err", err_unexp, 1);
    chk("idle_tag_outstanding", outstanding, 2);
    drain("t5_drain");

    // Reset with four requests outstanding; then a stale response arrives after reset.
    rsp_en = 0;
    for (int k = 0; k < 4; k++) send(0, 48'(k * 8), 64'h0, IW'(k));
    repeat (3) @(negedge clk);
    do_reset();
    #3 chk("midrst_outstanding", outstanding, 0);
    chk("midrst_req_rdy", req_rdy, 1);
    chk("midrst_err", err_unexp, 0);
    inject_tag = 0; inject_pend = 1;
    repeat (4) @(negedge clk);
    #3 chk("stale_rsp_err", err_unexp, 1);
    chk("stale_rsp_outstanding", outstanding, 0);
    do_reset();

    // Randomized traffic with back-pressure on both sides.
    rsp_en = 1; rq_stall_pct = 20; rsp_stall_pct = 25;
    rand_cycles(3000, 60);
    drain("rand_drain");
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_err", err_unexp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
